// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-timing and counter-width
// helpers used by both the receiver and the transmitter.
package uart_pkg;

    // Frame-level FSM states. PARITY is only visited when parity is compiled in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Clock cycles spent on one bit on the line (integer division).
    function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                   input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // Offset from the start edge to the middle of the start bit.
    function automatic int unsigned half_bit(input int unsigned clk_hz,
                                             input int unsigned bit_rate);
        return cycles_per_bit(clk_hz, bit_rate) / 2;
    endfunction

    // Width of a down-counter able to hold a full bit period.
    function automatic int unsigned cnt_width(input int unsigned clk_hz,
                                              input int unsigned bit_rate);
        return $clog2(cycles_per_bit(clk_hz, bit_rate) + 1);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line. Both flops reset to
// RESET_VAL so an idle-high line does not look like a start bit out of reset.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic dout
);

    logic meta;

    // Shift the raw line through two flops to settle metastability.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= RESET_VAL;
            dout <= RESET_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Asynchronous serial receiver (8N1 by default). Define UART_RX_PARITY_EN to
// accept one even-parity bit between the data bits and the stop bit.
//
// Handshake: uart_rx_valid, uart_rx_ferr and uart_rx_perr are one-cycle,
// mutually exclusive strobes with no back-pressure; uart_rx_data is valid
// in the strobe cycle and holds until the next good frame.
// uart_rx_state exposes the FSM state for observation.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_valid,
    output logic                    uart_rx_ferr,
    output logic                    uart_rx_perr,
    output uart_state_t             uart_rx_state
);

    localparam int unsigned CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int unsigned HB  = half_bit(CLK_HZ, BIT_RATE);
    localparam int unsigned CW  = cnt_width(CLK_HZ, BIT_RATE);
    localparam int unsigned BW  = $clog2(PAYLOAD_BITS);

    localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HB - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS - 1);

    logic                    rxd_s;
    uart_state_t             state;
    logic [CW-1:0]           cnt;
    logic [BW-1:0]           bit_idx;
    logic [PAYLOAD_BITS-1:0] shr;
    // Set once the line has been seen high in IDLE; a start needs a fresh
    // falling edge, so a held break cannot retrigger frames.
    logic                    armed;
`ifdef UART_RX_PARITY_EN
    logic                    par_bit;
    logic                    perr_q;
`endif

    uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .din    (uart_rxd),
        .dout   (rxd_s)
    );

    // Frame FSM: start validation, mid-bit sampling, stop check and strobes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shr           <= '0;
            armed         <= 1'b0;
            uart_rx_data  <= '0;
            uart_rx_valid <= 1'b0;
            uart_rx_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit       <= 1'b0;
            perr_q        <= 1'b0;
`endif
        end else begin
            uart_rx_valid <= 1'b0;
            uart_rx_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q        <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rxd_s) begin
                        armed <= 1'b1;
                    end else if (armed && uart_rx_en) begin
                        armed   <= 1'b0;
                        cnt     <= CNT_HALF;
                        bit_idx <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rxd_s) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= CNT_BIT;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shr <= {rxd_s, shr[PAYLOAD_BITS-1:1]};
                        cnt <= CNT_BIT;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        par_bit <= rxd_s;
                        cnt     <= CNT_BIT;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                        if (!rxd_s) begin
                            uart_rx_ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (^{shr, par_bit}) begin
                            perr_q <= 1'b1;
`endif
                        end else begin
                            uart_rx_data  <= shr;
                            uart_rx_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign uart_rx_perr = perr_q;
`else
    assign uart_rx_perr = 1'b0;
`endif

    assign uart_rx_state = state;

endmodule
